// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding and reset value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

    localparam int BP_CNT_W = 2;

    typedef logic [BP_CNT_W-1:0] bp_cnt_t;

    localparam bp_cnt_t BP_ST = 2'b11;
    localparam bp_cnt_t BP_WT = 2'b10;
    localparam bp_cnt_t BP_WN = 2'b01;
    localparam bp_cnt_t BP_SN = 2'b00;

    localparam bp_cnt_t BP_CNT_RESET = BP_WN;

    function automatic logic bp_cnt_taken(input bp_cnt_t cnt);
        return cnt[BP_CNT_W-1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter, stepping toward the resolved outcome.
// Latency: combinational.
// Backpressure: none.
module sat_counter2
    import bp_pkg::*;
(
    input  bp_cnt_t cnt,
    input  logic    taken,
    output bp_cnt_t cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != BP_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != BP_SN) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_2bit.sv
// Tagged direct-mapped BTB plus 2-bit PHT; BP_GSHARE_EN xors a global history into the fetch index.
// Latency: prediction combinational from current state; training commits at posedge clk (read-old).
// Backpressure: none, accepts one update per cycle.
module branch_predict_2bit
    import bp_pkg::*;
#(
    parameter int BTB_INDEX_BITS = 5,
    parameter int PHT_INDEX_BITS = 6,
    parameter int GHR_BITS       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               current_pc,
    output logic                      prediction,
    output logic [31:0]               predicted_pc,
    output logic [PHT_INDEX_BITS-1:0] pred_pht_idx,
    input  logic                      update_valid,
    input  logic [31:0]               update_pc,
    input  logic                      update_taken,
    input  logic [31:0]               update_target,
    input  logic [PHT_INDEX_BITS-1:0] update_pht_idx
);

    localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;
    localparam int TAG_W       = 32 - BTB_INDEX_BITS - 2;

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [31:0]       btb_target [BTB_ENTRIES];
    bp_cnt_t           pht        [PHT_ENTRIES];

    logic [BTB_INDEX_BITS-1:0] rd_btb_idx;
    logic [TAG_W-1:0]          rd_tag;
    logic [BTB_INDEX_BITS-1:0] wr_btb_idx;
    logic [TAG_W-1:0]          wr_tag;
    logic [PHT_INDEX_BITS-1:0] pc_pht_idx;
    logic [PHT_INDEX_BITS-1:0] fetch_idx;
    logic                      btb_hit;
    bp_cnt_t                   upd_cnt_next;
    logic                      unused_upd_bits;

    assign rd_btb_idx      = current_pc[BTB_INDEX_BITS+1:2];
    assign rd_tag          = current_pc[31:BTB_INDEX_BITS+2];
    assign wr_btb_idx      = update_pc[BTB_INDEX_BITS+1:2];
    assign wr_tag          = update_pc[31:BTB_INDEX_BITS+2];
    assign pc_pht_idx      = current_pc[PHT_INDEX_BITS+1:2];
    assign unused_upd_bits = ^update_pc[1:0];

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0]       ghr;
    logic [PHT_INDEX_BITS-1:0] ghr_ext;

    always_comb begin
        ghr_ext                = '0;
        ghr_ext[GHR_BITS-1:0]  = ghr;
    end

    assign fetch_idx = pc_pht_idx ^ ghr_ext;

    // History advances only on resolved branches, never speculatively at fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid) begin
            ghr <= (ghr << 1) | GHR_BITS'(update_taken);
        end
    end
`else
    localparam int unused_ghr_bits = GHR_BITS;

    assign fetch_idx = pc_pht_idx;
`endif

    // Outputs are forced to the fall-through view while reset is held.
    assign btb_hit      = btb_valid[rd_btb_idx] && (btb_tag[rd_btb_idx] == rd_tag);
    assign prediction   = !reset && btb_hit && bp_cnt_taken(pht[fetch_idx]);
    assign predicted_pc = prediction ? btb_target[rd_btb_idx] : current_pc + 32'd4;
    assign pred_pht_idx = reset ? pc_pht_idx : fetch_idx;

    sat_counter2 u_sat_counter2 (
        .cnt      (pht[update_pht_idx]),
        .taken    (update_taken),
        .cnt_next (upd_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (update_valid && update_taken) begin
            btb_valid[wr_btb_idx]  <= 1'b1;
            btb_tag[wr_btb_idx]    <= wr_tag;
            btb_target[wr_btb_idx] <= update_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= BP_CNT_RESET;
            end
        end else if (update_valid) begin
            pht[update_pht_idx] <= upd_cnt_next;
        end
    end

endmodule

// File: tb/tb_branch_predict_2bit.sv
// Bench for branch_predict_2bit: directed table, hand sequences and a randomized model comparison.
module tb_branch_predict_2bit;
    import bp_pkg::*;

    localparam int BTB_B = 5;
    localparam int PHT_B = 6;
    localparam int GHR_B = 6;
    localparam int NBTB  = 1 << BTB_B;
    localparam int NPHT  = 1 << PHT_B;

`ifdef BP_GSHARE_EN
    localparam logic [PHT_B-1:0] SC_IDX = 6'd1;
`else
    localparam logic [PHT_B-1:0] SC_IDX = 6'd0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      current_pc;
    logic             prediction;
    logic [31:0]      predicted_pc;
    logic [PHT_B-1:0] pred_pht_idx;
    logic             update_valid;
    logic [31:0]      update_pc;
    logic             update_taken;
    logic [31:0]      update_target;
    logic [PHT_B-1:0] update_pht_idx;

    bp_cnt_t sc_in, sc_out;
    logic    sc_taken;

    always #5 clk = ~clk;

    branch_predict_2bit #(
        .BTB_INDEX_BITS (BTB_B),
        .PHT_INDEX_BITS (PHT_B),
        .GHR_BITS       (GHR_B)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .prediction     (prediction),
        .predicted_pc   (predicted_pc),
        .pred_pht_idx   (pred_pht_idx),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_pht_idx (update_pht_idx)
    );

    sat_counter2 u_sc (
        .cnt      (sc_in),
        .taken    (sc_taken),
        .cnt_next (sc_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: counters as integers 0..3, BTB remembers the full branch PC.
    int          m_cnt  [NPHT];
    bit          m_bv   [NBTB];
    logic [31:0] m_bpc  [NBTB];
    logic [31:0] m_btgt [NBTB];
    int          m_ghr;

    function automatic void m_reset();
        for (int i = 0; i < NPHT; i++) m_cnt[i] = 1;
        for (int i = 0; i < NBTB; i++) begin
            m_bv[i]   = 1'b0;
            m_bpc[i]  = '0;
            m_btgt[i] = '0;
        end
        m_ghr = 0;
    endfunction

    function automatic int m_fetch_idx(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % 32'(NPHT));
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic p, output logic [31:0] npc,
                                      output int idx);
        int  bi;
        bit  hit;
        bi  = int'((pc >> 2) % 32'(NBTB));
        idx = m_fetch_idx(pc);
        hit = m_bv[bi] && ((m_bpc[bi] >> (BTB_B + 2)) == (pc >> (BTB_B + 2)));
        p   = hit && (m_cnt[idx] >= 2);
        npc = p ? m_btgt[bi] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                     input int idx);
        int bi;
        bi = int'((pc >> 2) % 32'(NBTB));
        if (taken) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        else       m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
        if (taken) begin
            m_bv[bi]   = 1'b1;
            m_bpc[bi]  = pc;
            m_btgt[bi] = tgt;
        end
        m_ghr = ((m_ghr << 1) | int'(taken)) % (1 << GHR_B);
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return 32'h0000_1000 + 32'(4 * $urandom_range(0, 127));
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        update_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic drive_update(input logic v, input logic [31:0] pc, input logic t,
                                input logic [31:0] tgt, input logic [PHT_B-1:0] idx);
        update_valid   = v;
        update_pc      = pc;
        update_taken   = t;
        update_target  = tgt;
        update_pht_idx = idx;
    endtask

    typedef struct {
        logic             uv;
        logic [31:0]      upc;
        logic             ut;
        logic [31:0]      utgt;
        logic [PHT_B-1:0] uidx;
        logic [31:0]      probe;
        logic             ep;
        logic [31:0]      eppc;
        logic [PHT_B-1:0] eidx;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic        ep;
        logic [31:0] eppc;
        int          eidx;
        logic        uv, ut, rst;
        logic [31:0] upc, utgt;
        int          uidx;

        reset      = 1'b1;
        current_pc = 32'h100;
        sc_in      = BP_SN;
        sc_taken   = 1'b0;
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, '0);
        m_reset();
        #1;
        check("reset_hold_pred", 32'(prediction), 32'h0);
        check("reset_hold_ppc", predicted_pc, 32'h104);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_pred", 32'(prediction), 32'h0);
        check("reset_ppc", predicted_pc, 32'h104);
        check("reset_idx", 32'(pred_pht_idx), 32'h0);
        check("reset_no_x", 32'($isunknown({prediction, predicted_pc, pred_pht_idx})), 32'h0);

        // Counter next-state, all eight input combinations.
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 2; t++) begin
                int exp_c;
                sc_in    = bp_cnt_t'(c);
                sc_taken = (t == 1);
                exp_c    = (t == 1) ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                #1;
                check("sat_counter2", 32'(sc_out), 32'(exp_c));
            end
        end

`ifndef BP_GSHARE_EN
        tbl[0]  = '{1'b1, 32'h100, 1'b1, 32'h200, 6'h00, 32'h100, 1'b1, 32'h200, 6'h00};
        tbl[1]  = '{1'b1, 32'h100, 1'b1, 32'h200, 6'h00, 32'h100, 1'b1, 32'h200, 6'h00};
        tbl[2]  = '{1'b1, 32'h100, 1'b1, 32'h200, 6'h00, 32'h100, 1'b1, 32'h200, 6'h00};
        tbl[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,   6'h00, 32'h100, 1'b1, 32'h200, 6'h00};
        tbl[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,   6'h00, 32'h100, 1'b0, 32'h104, 6'h00};
        tbl[5]  = '{1'b1, 32'h104, 1'b1, 32'h400, 6'h00, 32'h100, 1'b1, 32'h200, 6'h00};
        tbl[6]  = '{1'b1, 32'h180, 1'b1, 32'h300, 6'h20, 32'h100, 1'b0, 32'h104, 6'h00};
        tbl[7]  = '{1'b0, 32'h100, 1'b1, 32'hDEAD_0000, 6'h20, 32'h100, 1'b0, 32'h104, 6'h00};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,   6'h00, 32'h180, 1'b1, 32'h300, 6'h20};
        tbl[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   6'h00, 32'hFFFF_FFFC, 1'b0, 32'h0, 6'h3F};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   6'h00, 32'h104, 1'b0, 32'h108, 6'h01};

        for (int i = 0; i < 11; i++) begin
            drive_update(tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, tbl[i].uidx);
            current_pc = tbl[i].probe;
            @(posedge clk);
            #1;
            update_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_pred", i), 32'(prediction), 32'(tbl[i].ep));
            check($sformatf("tbl%0d_ppc", i), predicted_pc, tbl[i].eppc);
            check($sformatf("tbl%0d_idx", i), 32'(pred_pht_idx), 32'(tbl[i].eidx));
        end
`endif

        // Same-cycle update is read-old, visible one cycle later.
        do_reset();
        current_pc = 32'h100;
        drive_update(1'b1, 32'h100, 1'b1, 32'h200, SC_IDX);
        #1;
        check("same_cycle_old_pred", 32'(prediction), 32'h0);
        check("same_cycle_old_ppc", predicted_pc, 32'h104);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        check("same_cycle_new_pred", 32'(prediction), 32'h1);
        check("same_cycle_new_ppc", predicted_pc, 32'h200);

        // Reset wins over a simultaneous update and clears the trained entry.
        reset = 1'b1;
        drive_update(1'b1, 32'h100, 1'b1, 32'h500, SC_IDX);
        #1;
        check("rst_upd_hold_pred", 32'(prediction), 32'h0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        update_valid = 1'b0;
        #1;
        check("rst_upd_pred", 32'(prediction), 32'h0);
        check("rst_upd_ppc", predicted_pc, 32'h104);
        check("rst_upd_idx", 32'(pred_pht_idx), 32'h0);
        m_reset();

`ifdef BP_GSHARE_EN
        for (int k = 0; k < 4; k++) begin
            drive_update(1'b1, 32'h100, 1'b1, 32'h200, PHT_B'(m_fetch_idx(32'h100)));
            m_update(32'h100, 1'b1, 32'h200, m_fetch_idx(32'h100));
            @(posedge clk);
            #1;
            update_valid = 1'b0;
        end
        current_pc = 32'h100;
        #1;
        check("gshare_idx_after4", 32'(pred_pht_idx), 32'h0F);
        do_reset();
        #1;
        check("gshare_idx_reset", 32'(pred_pht_idx), 32'h00);
`endif

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 63) == 0);
            uv   = ($urandom_range(0, 9) < 6);
            upc  = rand_pc();
            ut   = $urandom_range(0, 1) == 1;
            utgt = $urandom() & 32'hFFFF_FFFC;
            uidx = ($urandom_range(0, 1) == 1) ? m_fetch_idx(upc) : int'($urandom_range(0, NPHT - 1));
            reset      = rst;
            current_pc = rand_pc();
            drive_update(uv, upc, ut, utgt, PHT_B'(uidx));
            #1;
            if (rst) begin
                ep   = 1'b0;
                eppc = current_pc + 32'd4;
                eidx = int'((current_pc >> 2) % 32'(NPHT));
            end else begin
                m_predict(current_pc, ep, eppc, eidx);
            end
            check("rnd_pred", 32'(prediction), 32'(ep));
            check("rnd_ppc", predicted_pc, eppc);
            check("rnd_idx", 32'(pred_pht_idx), 32'(eidx));
            @(posedge clk);
            if (rst) m_reset();
            else if (uv) m_update(upc, ut, utgt, uidx);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
